// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Board-level reset controller. It waits for the PLL lock to be stable, then
// holds the SoC in reset for a minimum time, then releases it with a
// registered, glitch-free deassertion. It also records why the last reset
// happened and counts run-time resets.
//
// Parameters:
//   LOCK_STABLE_CYCLES  consecutive synchronized-lock cycles before hold (>= 1)
//   HOLD_CYCLES         minimum reset hold after stable lock or button (>= 1)
//
// Ports:
//   clk_in           in   1  system clock from the PLL
//   reset_in         in   1  global reset, asynchronous assert, active-low
//   locked_in        in   1  PLL lock, asynchronous to clk_in
//   button_pulse_in  in   1  single-cycle pulse synchronous to clk_in
//   reset_out        out  1  active-low SoC reset (high only in RUN)
//   reset_cause_out  out  2  00 power-on, 01 lock loss, 10 button
//   reset_count_out  out  8  run-time resets since reset_in, saturating
// -----------------------------------------------------------------------------
module reset_sequencer #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES        = 16
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       locked_in,
    input  logic       button_pulse_in,
    output logic       reset_out,
    output logic [1:0] reset_cause_out,
    output logic [7:0] reset_count_out
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > HOLD_CYCLES) ?
                                LOCK_STABLE_CYCLES : HOLD_CYCLES;
    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CW-1:0] CNT_ZERO    = CW'(0);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_LOCK   = 2'b01;
    localparam logic [1:0] CAUSE_BUTTON = 2'b10;

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        LOCK_STABLE = 2'd1,
        HOLD        = 2'd2,
        RUN         = 2'd3
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_count;
    logic          r_lock_meta;
    logic          r_lock_sync;
    logic          r_reset_n;
    logic [1:0]    r_cause;
    logic [7:0]    r_rst_count;
    logic [7:0]    w_rst_count_inc;

    // Saturating increment of the run-time reset counter.
    assign w_rst_count_inc = (r_rst_count == 8'hFF) ? r_rst_count : (r_rst_count + 8'd1);

    // Two-flop synchronizer bringing the asynchronous lock into clk_in.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_lock_meta <= locked_in;
            r_lock_sync <= r_lock_meta;
        end
    end

    // Sequencer FSM with registered reset, cause and count outputs. reset_out
    // is written on exactly the transitions into and out of RUN, so it always
    // mirrors the state register and cannot glitch.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            r_state     <= WAIT_LOCK;
            r_count     <= CNT_ZERO;
            r_reset_n   <= 1'b0;
            r_cause     <= CAUSE_POR;
            r_rst_count <= 8'd0;
        end else begin
            case (r_state)
                WAIT_LOCK: begin
                    if (r_lock_sync) begin
                        r_state <= LOCK_STABLE;
                        r_count <= CNT_ZERO;
                    end
                end
                LOCK_STABLE: begin
                    if (!r_lock_sync) begin
                        r_state <= WAIT_LOCK;
                        r_count <= CNT_ZERO;
                    end else if (r_count == STABLE_LAST) begin
                        r_state <= HOLD;
                        r_count <= CNT_ZERO;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (!r_lock_sync) begin
                        r_state <= WAIT_LOCK;
                        r_count <= CNT_ZERO;
                        r_cause <= CAUSE_LOCK;
                    end else if (button_pulse_in) begin
                        // A button press restarts the full hold window.
                        r_count <= CNT_ZERO;
                        r_cause <= CAUSE_BUTTON;
                    end else if (r_count == HOLD_LAST) begin
                        r_state   <= RUN;
                        r_count   <= CNT_ZERO;
                        r_reset_n <= 1'b1;
                    end else begin
                        r_count <= r_count + CNT_ONE;
                    end
                end
                RUN: begin
                    // Lock loss takes priority; either exit counts once.
                    if (!r_lock_sync) begin
                        r_state     <= WAIT_LOCK;
                        r_count     <= CNT_ZERO;
                        r_reset_n   <= 1'b0;
                        r_cause     <= CAUSE_LOCK;
                        r_rst_count <= w_rst_count_inc;
                    end else if (button_pulse_in) begin
                        r_state     <= HOLD;
                        r_count     <= CNT_ZERO;
                        r_reset_n   <= 1'b0;
                        r_cause     <= CAUSE_BUTTON;
                        r_rst_count <= w_rst_count_inc;
                    end
                end
                default: begin
                    r_state   <= WAIT_LOCK;
                    r_count   <= CNT_ZERO;
                    r_reset_n <= 1'b0;
                end
            endcase
        end
    end

    assign reset_out       = r_reset_n;
    assign reset_cause_out = r_cause;
    assign reset_count_out = r_rst_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Directed bench for reset_sequencer (LOCK_STABLE_CYCLES=4, HOLD_CYCLES=2).
// A behavioural model tracks, edge by edge, how long the synchronized lock has
// been high, how much hold time remains and whether the SoC is running; a
// compare process checks all outputs against it on every falling edge.
// Directed sequences add hand-computed edge-exact expectations.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

    localparam int L = 4;
    localparam int H = 2;

    logic       clk_in;
    logic       reset_in;
    logic       locked_in;
    logic       button_pulse_in;
    logic       reset_out;
    logic [1:0] reset_cause_out;
    logic [7:0] reset_count_out;

    int n_checks = 0;
    int n_fail   = 0;

    reset_sequencer #(
        .LOCK_STABLE_CYCLES(L),
        .HOLD_CYCLES       (H)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .locked_in      (locked_in),
        .button_pulse_in(button_pulse_in),
        .reset_out      (reset_out),
        .reset_cause_out(reset_cause_out),
        .reset_count_out(reset_count_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_samp1, m_samp2;  // lock as sampled one and two edges ago
    bit m_run;             // SoC released
    int m_hold_left;       // remaining hold edges, 0 = not holding
    int m_stable;          // edges the synchronized lock has been seen high
    int m_cause;
    int m_cnt;

    always @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            m_samp1 = 1'b0; m_samp2 = 1'b0; m_run = 1'b0;
            m_hold_left = 0; m_stable = 0; m_cause = 0; m_cnt = 0;
        end else begin
            if (!m_samp2) begin
                if (m_run || m_hold_left > 0) m_cause = 1;
                if (m_run && m_cnt < 255) m_cnt++;
                m_run = 1'b0; m_hold_left = 0; m_stable = 0;
            end else if (m_run) begin
                if (button_pulse_in) begin
                    m_run = 1'b0; m_hold_left = H; m_cause = 2;
                    if (m_cnt < 255) m_cnt++;
                end
            end else if (m_hold_left > 0) begin
                if (button_pulse_in) begin
                    m_hold_left = H; m_cause = 2;
                end else begin
                    m_hold_left--;
                    if (m_hold_left == 0) m_run = 1'b1;
                end
            end else begin
                // first high edge leaves WAIT_LOCK, then L stable edges
                m_stable++;
                if (m_stable == L + 1) begin
                    m_hold_left = H; m_stable = 0;
                end
            end
            m_samp2 = m_samp1;
            m_samp1 = locked_in;
        end
    end

    // Compare DUT outputs against the model away from the active edge.
    always @(negedge clk_in) begin
        check("model reset_out", int'(reset_out), int'(m_run));
        check("model cause", int'(reset_cause_out), m_cause);
        check("model count", int'(reset_count_out), m_cnt);
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_run(input string name, input int limit);
        int n;
        n = 0;
        while (reset_out !== 1'b1 && n < limit) begin
            tick();
            n++;
        end
        check(name, int'(reset_out === 1'b1), 1);
    endtask

    int cnt_before;

    initial begin
        reset_in        = 1'b0;
        locked_in       = 1'b1;
        button_pulse_in = 1'b0;
        #2;
        check("reset reset_out", int'(reset_out), 0);
        check("reset cause", int'(reset_cause_out), 0);
        check("reset count", int'(reset_count_out), 0);
        #21 reset_in = 1'b1;

        // Power-up: release at edge 3+L+H = 9.
        repeat (8) tick();
        check("powerup edge8 low", int'(reset_out), 0);
        tick();
        check("powerup edge9 high", int'(reset_out), 1);
        check("powerup cause", int'(reset_cause_out), 0);
        check("powerup count", int'(reset_count_out), 0);

        // Button in RUN: low for exactly H cycles.
        tick();
        button_pulse_in = 1'b1;
        tick();
        button_pulse_in = 1'b0;
        check("button t low", int'(reset_out), 0);
        check("button cause", int'(reset_cause_out), 2);
        check("button count", int'(reset_count_out), 1);
        tick();
        check("button t+1 low", int'(reset_out), 0);
        tick();
        check("button t+2 high", int'(reset_out), 1);

        // Lock low for 3 samples in RUN.
        tick();
        locked_in = 1'b0;
        tick();                                    // edge k
        tick();                                    // k+1
        check("lockloss k+1 high", int'(reset_out), 1);
        tick();                                    // k+2
        check("lockloss k+2 low", int'(reset_out), 0);
        check("lockloss cause", int'(reset_cause_out), 1);
        check("lockloss count", int'(reset_count_out), 2);
        locked_in = 1'b1;
        repeat (8) tick();                         // k+10
        check("relock k+10 low", int'(reset_out), 0);
        tick();                                    // k+11
        check("relock k+11 high", int'(reset_out), 1);

        // Lock loss and button reach the FSM on the same edge.
        tick();
        cnt_before = int'(reset_count_out);
        locked_in = 1'b0;
        tick();                                    // k
        tick();                                    // k+1
        button_pulse_in = 1'b1;
        tick();                                    // k+2
        button_pulse_in = 1'b0;
        check("simul reset_out", int'(reset_out), 0);
        check("simul cause", int'(reset_cause_out), 1);
        check("simul count", int'(reset_count_out), cnt_before + 1);

        // Relock, then a glitch seen while LOCK_STABLE counter = 2.
        locked_in = 1'b1;
        repeat (3) tick();                         // k+5: LOCK_STABLE entered
        locked_in = 1'b0;
        tick();                                    // k+6
        locked_in = 1'b1;
        tick();                                    // k+7
        tick();                                    // k+8: back to WAIT_LOCK
        repeat (6) tick();                         // k+14
        check("glitch k+14 low", int'(reset_out), 0);
        tick();                                    // k+15
        check("glitch k+15 high", int'(reset_out), 1);
        check("glitch cause", int'(reset_cause_out), 1);

        // 300 button resets drive the count into saturation.
        for (int i = 0; i < 300; i++) begin
            tick();
            button_pulse_in = 1'b1;
            tick();
            button_pulse_in = 1'b0;
            wait_run("sat release", 10);
        end
        check("sat count", int'(reset_count_out), 255);
        check("sat cause", int'(reset_cause_out), 2);

        // Enter HOLD, then assert reset_in between clock edges.
        tick();
        button_pulse_in = 1'b1;
        tick();
        button_pulse_in = 1'b0;
        #2 reset_in = 1'b0;
        #1;
        check("async reset_out", int'(reset_out), 0);
        check("async cause", int'(reset_cause_out), 0);
        check("async count", int'(reset_count_out), 0);
        repeat (3) tick();
        check("held reset_out", int'(reset_out), 0);
        check("held count", int'(reset_count_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Board-level reset controller for the Arty A7 top level. It sits between the PLL lock indication / debounced reset-button pulse and the SoC. It produces the SoC's active-low reset with three guarantees: release only after lock has been stable for a programmable time, a guaranteed minimum hold, and glitch-free synchronous deassertion. It also reports why the last reset occurred and how many run-time resets have happened.

## Interface
Parameters:
- LOCK_STABLE_CYCLES, default 1024: consecutive cycles of synchronized lock required before hold starts (>= 1).
- HOLD_CYCLES, default 16: minimum cycles reset is held after lock is stable or after a button pulse (>= 1).

Ports:
- clk_in  input  1  slow system clock from the PLL.
- reset_in  input  1  global reset; asynchronous assert, active-low.
- locked_in  input  1  PLL lock, asynchronous to clk_in; internally passed through a 2-flop synchronizer cleared to 0 by reset_in.
- button_pulse_in  input  1  single-cycle pulse, synchronous to clk_in (debounced button rising edge).
- reset_out  output  1  active-low SoC reset, registered.
- reset_cause_out  output  2  00 power-on, 01 lock loss, 10 button; 11 never driven.
- reset_count_out  output  8  run-time resets since reset_in, saturating at 255.

## Operation
- State machine: WAIT_LOCK, LOCK_STABLE, HOLD, RUN. One counter, wide enough for max(LOCK_STABLE_CYCLES, HOLD_CYCLES).
- Async reset (reset_in = 0) drives the following values:
  - state = WAIT_LOCK, counter = 0, synchronizer flops = 0.
  - reset_out = 0, reset_cause_out = 00, reset_count_out = 0.
- WAIT_LOCK: when synchronized lock = 1, go to LOCK_STABLE with counter = 0.
- LOCK_STABLE:
  - If synchronized lock = 0, go to WAIT_LOCK with counter = 0.
  - Else if counter = LOCK_STABLE_CYCLES-1, go to HOLD with counter = 0.
  - Else increment counter.
- HOLD (priority order):
  - Lock low: go to WAIT_LOCK, cause = 01.
  - Button pulse: counter = 0, stay in HOLD, cause = 10.
  - Counter = HOLD_CYCLES-1: go to RUN.
  - Otherwise increment counter.
- RUN:
  - Lock low: go to WAIT_LOCK, cause = 01, count + 1.
  - Else button pulse: go to HOLD, counter = 0, cause = 10, count + 1.
  - Lock loss wins over a simultaneous button pulse; that event counts once.
- Button pulses in WAIT_LOCK or LOCK_STABLE are ignored. Cause and count are unchanged.
- reset_out is a flop updated on the same edge as the state register. It equals 1 exactly when the state register holds RUN, so it never glitches.
- reset_count_out increments only on RUN exits. It holds at 255 once reached.
- reset_cause_out changes only on the edge of the transition it records, and holds otherwise.

## Timing
- Locked_in to internal use takes 2 edges. A lock change sampled at edge k is acted on at edge k+2.
- Power-up: reset_in released with locked_in already high.
  - Synchronizer output goes high at edge 2.
  - LOCK_STABLE is entered at edge 3.
  - HOLD is entered at edge 3+LOCK_STABLE_CYCLES.
  - reset_out rises at edge 3+LOCK_STABLE_CYCLES+HOLD_CYCLES.
- Lock loss in RUN: locked_in low before edge k makes reset_out fall at edge k+2.
- Button pulse high in the cycle before edge t (in RUN):
  - reset_out falls at edge t.
  - reset_out rises at edge t+HOLD_CYCLES, unless interrupted.
- A button pulse in HOLD restarts a full HOLD_CYCLES window from its edge.
- A lock glitch shorter than the synchronizer delay can still be caught. Any synchronized low restarts the whole sequence from WAIT_LOCK.
- reset_in assertion mid-sequence forces all reset values immediately, with no clock needed.

## Test plan
- LOCK_STABLE_CYCLES=4, HOLD_CYCLES=2, locked_in=1 before reset_in release:
  - reset_out rises exactly at edge 9 after release.
  - cause = 00, count = 0.
- In RUN, one-cycle button pulse:
  - reset_out low for exactly 2 cycles, then high.
  - cause = 10, count = 1.
- In RUN, locked_in low for 3 cycles, then high:
  - reset_out falls 2 edges later.
  - Full 4+2-cycle sequence after lock returns.
  - cause = 01, count + 1.
- Simultaneous lock loss and button pulse in RUN: state WAIT_LOCK, cause = 01, count increments by exactly 1.
- locked_in drops at LOCK_STABLE counter = 2: return to WAIT_LOCK, and the counter restarts from 0 on relock.
- 300 button-driven resets: count saturates at 255; then assert reset_in mid-HOLD → all outputs return to their reset values asynchronously.
